// File: rtl/csa_accum_pkg.sv
// rtl/csa_accum_pkg.sv - shared state type and width helpers for the carry-save accumulator
package csa_accum_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Wide enough that MAX_BEATS full beats of NUM_LANES words never wrap.
  function automatic int calc_bit_len(input int word_len, input int num_lanes, input int max_beats);
    return word_len + $clog2(num_lanes * max_beats);
  endfunction

  function automatic int calc_count_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/compressor_tree_3_to_2.sv
// rtl/compressor_tree_3_to_2.sv - reduces NUM_ELEMENTS words to a redundant sum/carry pair
module compressor_tree_3_to_2 #(
  parameter int NUM_ELEMENTS = 6,
  parameter int BIT_LEN      = 22
) (
  input  logic [BIT_LEN-1:0] elements_i [NUM_ELEMENTS],
  output logic [BIT_LEN-1:0] sum_o,
  output logic [BIT_LEN-1:0] carry_o
);

  logic [BIT_LEN-1:0] s_v;
  logic [BIT_LEN-1:0] c_v;
  logic [BIT_LEN-1:0] t_v;

  // Chain of full-adder rows; the carry out of the top bit is dropped, keeping results mod 2^BIT_LEN.
  always_comb begin
    s_v = elements_i[0];
    c_v = elements_i[1];
    t_v = '0;
    for (int i = 2; i < NUM_ELEMENTS; i++) begin
      t_v = s_v ^ c_v ^ elements_i[i];
      c_v = ((s_v & c_v) | (s_v & elements_i[i]) | (c_v & elements_i[i])) << 1;
      s_v = t_v;
    end
    sum_o   = s_v;
    carry_o = c_v;
  end

endmodule

// File: rtl/csa_accum_sequencer.sv
// rtl/csa_accum_sequencer.sv - multi-beat carry-save reduction with a single resolve add per result
module csa_accum_sequencer
  import csa_accum_pkg::*;
#(
  parameter int  NUM_LANES = 4,
  parameter int  WORD_LEN  = 16,
  parameter int  MAX_BEATS = 16,
  localparam int BIT_LEN   = calc_bit_len(WORD_LEN, NUM_LANES, MAX_BEATS),
  localparam int CNT_W     = calc_count_w(MAX_BEATS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_LEN-1:0] in_data [NUM_LANES],
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_LEN-1:0]  out_sum,
  output logic [CNT_W-1:0]    out_count,
  output logic                out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  state_e             state_q;
  logic [BIT_LEN-1:0] acc_s_q;
  logic [BIT_LEN-1:0] acc_c_q;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;
  logic [BIT_LEN-1:0] sum_q;

  logic [BIT_LEN-1:0] acc_s_d;
  logic [BIT_LEN-1:0] acc_c_d;
  logic [CNT_W-1:0]   count_d;
  logic [BIT_LEN-1:0] sum_d;
  logic [BIT_LEN-1:0] elems [NUM_LANES+2];
  logic               accept;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      elems[i] = BIT_LEN'(in_data[i]);
    end
    elems[NUM_LANES]   = acc_s_q;
    elems[NUM_LANES+1] = acc_c_q;
  end

  compressor_tree_3_to_2 #(
    .NUM_ELEMENTS(NUM_LANES + 2),
    .BIT_LEN     (BIT_LEN)
  ) u_tree (
    .elements_i(elems),
    .sum_o     (acc_s_d),
    .carry_o   (acc_c_d)
  );

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == OUTPUT) && !rst;
  assign accept    = in_valid && in_ready;
  assign count_d   = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
  assign sum_d     = acc_s_q + acc_c_q;

  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_s_q <= '0;
      acc_c_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_s_q <= acc_s_d;
            acc_c_q <= acc_c_d;
            count_q <= count_d;
            if (count_q == CNT_MAX) ovf_q <= 1'b1;
            if (in_last) state_q <= RESOLVE;
          end
        end
        RESOLVE: begin
          sum_q   <= sum_d;
          state_q <= OUTPUT;
        end
        OUTPUT: begin
          // Handshake clears the reduction so the next beat starts fresh.
          if (out_ready) begin
            state_q <= ACCUM;
            acc_s_q <= '0;
            acc_c_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// tb/tb_csa_accum_sequencer.sv - directed bench with a queue-based reference model
module tb_csa_accum_sequencer;

  localparam int LANES = 4;
  localparam int MAXB  = 16;
  localparam longint MODV = 64'd1 << 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data [LANES];
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [21:0] out_sum;
  logic [4:0]  out_count;
  logic        out_ovf;

  csa_accum_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    longint sum;
    int     cnt;
    bit     ovf;
    int     vcyc;
  } res_t;

  res_t   q[$];
  longint total = 0;
  int     beats = 0;
  bit     busy  = 0;
  bit     armed = 0;

  // Reference: arithmetic sum of accepted lanes, result visible two cycles after the last beat.
  always @(negedge clk) begin
    bit     exp_ready;
    bit     exp_valid;
    longint lane_sum;
    res_t   r;
    exp_ready = !busy && !rst;
    exp_valid = !rst && (q.size() > 0) && (cyc >= q[0].vcyc);
    if (armed) begin
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_valid);
      if (!rst) begin
        if (busy) begin
          chk("out_count", out_count, q[0].cnt);
          chk("out_ovf", out_ovf, q[0].ovf);
          if (exp_valid) chk("out_sum", out_sum, q[0].sum);
        end else begin
          chk("live_count", out_count, (beats > MAXB) ? MAXB : beats);
          chk("live_ovf", out_ovf, beats > MAXB);
        end
      end
    end
    if (rst) begin
      q.delete();
      total = 0;
      beats = 0;
      busy  = 0;
      armed = 1;
    end else begin
      if (exp_valid && out_ready) begin
        void'(q.pop_front());
        busy = 0;
      end
      if (in_valid && exp_ready) begin
        lane_sum = 0;
        for (int i = 0; i < LANES; i++) lane_sum += in_data[i];
        total += lane_sum;
        beats++;
        if (in_last) begin
          r.sum  = total % MODV;
          r.cnt  = (beats > MAXB) ? MAXB : beats;
          r.ovf  = beats > MAXB;
          r.vcyc = cyc + 2;
          q.push_back(r);
          busy  = 1;
          total = 0;
          beats = 0;
        end
      end
    end
  end

  task automatic set_data(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    in_data[0] = a;
    in_data[1] = b;
    in_data[2] = c;
    in_data[3] = d;
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input bit last, input bit bubbles, output int acc_cyc);
    bit done;
    if (bubbles) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    set_data(a, b, c, d);
    in_last  = last;
    in_valid = 1'b1;
    done = 0;
    acc_cyc = -1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string tag, input longint es, input int ec, input bit eo,
                            input bit pre_ready, input int stall, output int vcyc);
    bit seen;
    out_ready = pre_ready;
    seen = 0;
    vcyc = -1;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        vcyc = cyc;
        chk({tag, "_sum"}, out_sum, es);
        chk({tag, "_count"}, out_count, ec);
        chk({tag, "_ovf"}, out_ovf, eo);
      end
    end
    if (!seen) chk({tag, "_valid_timeout"}, 0, 1);
    @(posedge clk); #1;
    if (!pre_ready) begin
      if (stall > 0) begin
        set_data(16'd9, 16'd9, 16'd9, 16'd9);
        in_last  = 1'b1;
        in_valid = 1'b1;
        repeat (stall - 1) begin
          @(posedge clk); #1;
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_after"}, in_ready, 1);
    @(posedge clk); #1;
  endtask

  int ac;
  int vc;

  initial begin
    set_data(16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_count", out_count, 0);
    chk("post_rst_ovf", out_ovf, 0);
    @(posedge clk); #1;

    send_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b1, 1'b0, ac);
    get_result("single", 10, 1, 0, 1'b1, 0, vc);
    chk("single_latency", vc - ac, 2);

    for (int b = 1; b <= 16; b++)
      send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, b == 16, 1'b0, ac);
    get_result("full16", 64'h3FFFC0, 16, 0, 1'b0, 5, vc);

    for (int b = 1; b <= 17; b++)
      send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, b == 17, 1'b0, ac);
    get_result("ovf17", 64'h03FFBC, 16, 1, 1'b0, 0, vc);

    send_beat(16'd100, 16'd200, 16'd300, 16'd400, 1'b0, 1'b1, ac);
    send_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b1, 1'b1, ac);
    get_result("two_beat", 1004, 2, 0, 1'b0, 2, vc);

    for (int b = 0; b < 3; b++)
      send_beat(16'd7, 16'd7, 16'd7, 16'd7, 1'b0, 1'b1, ac);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_count", out_count, 0);
    @(posedge clk); #1;
    send_beat(16'd5, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, ac);
    get_result("after_rst", 5, 1, 0, 1'b0, 1, vc);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
